// File: rtl/pid_ctrl.sv
// pid_ctrl: multi-cycle PID controller shared by the altitude, attitude and yaw loops.
//
// Each sample runs through the same five states: Idle, Mul, Sum, Clamp, Out.
//  - Idle:  accept a setpoint/measurement pair and its gains.
//  - Mul:   form the P, I-increment and D products.
//  - Sum:   form the integrator candidate (with anti-windup) and the total.
//  - Clamp: clamp the total into the unsigned command.
//  - Out:   hold the result until the consumer takes it.
// With the result taken immediately the latency is 4 cycles and the minimum sample period is 5.
//
// Optional feature: define PID_DERIV_FILTER_EN to pass the D term through a first-order IIR
// (coefficient 2^-DF_SHIFT). Without it the raw D term is used and no filter state exists.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   sink_valid/ready      input handshake; ready only in Idle
//   sink_setpoint/data    signed setpoint and measurement (DATA_W)
//   sink_kp/ki/kd         unsigned gains (GAIN_W), k/2^FRAC_SHIFT
//   clear                 zero integrator, derivative history, saturation history, filter
//   source_valid/ready    output handshake
//   source_pid            command clamped to [0, OUT_MAX] (OUT_W)
//   source_sat            command was clamped high or low
module pid_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned GAIN_W     = 8,
  parameter int unsigned FRAC_SHIFT = 4,
  parameter int unsigned OUT_W      = 15,
  parameter int unsigned OUT_MAX    = 12240,
  parameter int unsigned I_MAX      = 12240,
  parameter int unsigned DF_SHIFT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic [DATA_W-1:0] sink_setpoint,
  input  logic [DATA_W-1:0] sink_data,
  input  logic [GAIN_W-1:0] sink_kp,
  input  logic [GAIN_W-1:0] sink_ki,
  input  logic [GAIN_W-1:0] sink_kd,
  input  logic              clear,
  output logic              source_valid,
  input  logic              source_ready,
  output logic [OUT_W-1:0]  source_pid,
  output logic              source_sat
);

  localparam int unsigned ACC_W = DATA_W + GAIN_W + 4;
  localparam int unsigned ERR_W = DATA_W + 1;
  localparam int unsigned DIF_W = DATA_W + 2;

  localparam logic signed [ACC_W-1:0] OutMaxS = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] IMaxS   = ACC_W'(I_MAX);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMul   = 3'd1,
    StSum   = 3'd2,
    StClamp = 3'd3,
    StOut   = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   state_bad;

  // Latched sample
  logic        [DATA_W-1:0] sp_q, sp_d, meas_q, meas_d;
  logic        [GAIN_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  // Mul stage
  logic signed [ERR_W-1:0]  err_prev_q, err_prev_d;
  logic                     seen_q, seen_d;     // a sample has been seen since reset/clear
  logic signed [ACC_W-1:0]  p_q, p_d, i_inc_q, i_inc_d, d_q, d_d;
  // Sum stage
  logic signed [ACC_W-1:0]  i_cand_q, i_cand_d, sum_q, sum_d;
  logic                     i_wr_q, i_wr_d;     // dropped by clear so Clamp writes a zero
  // Clamp stage and persistent state
  logic signed [ACC_W-1:0]  i_acc_q, i_acc_d;
  logic                     sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
  logic        [OUT_W-1:0]  pid_q, pid_d;
  logic                     sat_q, sat_d;
  logic                     valid_q, valid_d;
  logic                     sink_ready_q, sink_ready_d;

`ifdef PID_DERIV_FILTER_EN
  logic signed [ACC_W-1:0]  d_f_q, d_f_d;
  logic signed [ACC_W-1:0]  d_f_step;
`else
  // DF_SHIFT only matters when the filter is built.
  logic unused_df_shift;
  assign unused_df_shift = ^DF_SHIFT;
`endif

  // Datapath
  logic signed [ERR_W-1:0] err_c;
  logic signed [DIF_W-1:0] diff_c;
  logic signed [ACC_W-1:0] err_x, diff_x, kp_x, ki_x, kd_x;
  logic signed [ACC_W-1:0] p_prod, i_prod, d_prod;
  logic signed [ACC_W-1:0] i_sum, i_cand_c, d_use, sum_c;
  logic                    i_hold;

  always_comb begin
    err_c  = {sp_q[DATA_W-1], sp_q} - {meas_q[DATA_W-1], meas_q};
    // First sample after reset/clear uses err as err_prev, so the difference is zero.
    diff_c = seen_q ? ({err_c[ERR_W-1], err_c} - {err_prev_q[ERR_W-1], err_prev_q}) : '0;

    err_x  = {{(ACC_W-ERR_W){err_c[ERR_W-1]}}, err_c};
    diff_x = {{(ACC_W-DIF_W){diff_c[DIF_W-1]}}, diff_c};
    kp_x   = {{(ACC_W-GAIN_W){1'b0}}, kp_q};
    ki_x   = {{(ACC_W-GAIN_W){1'b0}}, ki_q};
    kd_x   = {{(ACC_W-GAIN_W){1'b0}}, kd_q};

    p_prod = kp_x * err_x;
    i_prod = ki_x * err_x;
    d_prod = kd_x * diff_x;

    // Conditional integration: don't push further into a saturation the output already hit.
    i_hold = (sat_hi_q && !i_inc_q[ACC_W-1] && (i_inc_q != '0)) ||
             (sat_lo_q && i_inc_q[ACC_W-1]);
    i_sum  = i_acc_q + i_inc_q;
    if (i_hold) begin
      i_cand_c = i_acc_q;
    end else if (i_sum[ACC_W-1]) begin
      i_cand_c = '0;
    end else if (i_sum > IMaxS) begin
      i_cand_c = IMaxS;
    end else begin
      i_cand_c = i_sum;
    end

`ifdef PID_DERIV_FILTER_EN
    d_f_step = d_q - d_f_q;
    d_use    = d_f_q + (d_f_step >>> DF_SHIFT);
`else
    d_use    = d_q;
`endif

    sum_c = p_q + i_cand_c + d_use;
  end

  // Next-state
  always_comb begin
    state_d      = state_q;
    state_bad    = 1'b0;
    sp_d         = sp_q;
    meas_d       = meas_q;
    kp_d         = kp_q;
    ki_d         = ki_q;
    kd_d         = kd_q;
    err_prev_d   = err_prev_q;
    seen_d       = seen_q;
    p_d          = p_q;
    i_inc_d      = i_inc_q;
    d_d          = d_q;
    i_cand_d     = i_cand_q;
    sum_d        = sum_q;
    i_wr_d       = i_wr_q;
    i_acc_d      = i_acc_q;
    sat_hi_d     = sat_hi_q;
    sat_lo_d     = sat_lo_q;
    pid_d        = pid_q;
    sat_d        = sat_q;
    valid_d      = valid_q;
    sink_ready_d = sink_ready_q;
`ifdef PID_DERIV_FILTER_EN
    d_f_d        = d_f_q;
`endif

    case (state_q)
      StIdle: begin
        if (sink_valid) begin
          sp_d         = sink_setpoint;
          meas_d       = sink_data;
          kp_d         = sink_kp;
          ki_d         = sink_ki;
          kd_d         = sink_kd;
          sink_ready_d = 1'b0;
          state_d      = StMul;
        end
      end
      StMul: begin
        err_prev_d = err_c;
        seen_d     = 1'b1;
        p_d        = p_prod >>> FRAC_SHIFT;
        i_inc_d    = i_prod >>> FRAC_SHIFT;
        d_d        = d_prod >>> FRAC_SHIFT;
        state_d    = StSum;
      end
      StSum: begin
        i_cand_d = i_cand_c;
        sum_d    = sum_c;
        i_wr_d   = 1'b1;
`ifdef PID_DERIV_FILTER_EN
        d_f_d    = d_use;
`endif
        state_d  = StClamp;
      end
      StClamp: begin
        i_acc_d = i_wr_q ? i_cand_q : '0;
        if (sum_q[ACC_W-1]) begin
          pid_d    = '0;
          sat_d    = 1'b1;
          sat_hi_d = 1'b0;
          sat_lo_d = 1'b1;
        end else if (sum_q > OutMaxS) begin
          pid_d    = OUT_W'(OUT_MAX);
          sat_d    = 1'b1;
          sat_hi_d = 1'b1;
          sat_lo_d = 1'b0;
        end else begin
          pid_d    = sum_q[OUT_W-1:0];
          sat_d    = 1'b0;
          sat_hi_d = 1'b0;
          sat_lo_d = 1'b0;
        end
        valid_d = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (source_ready) begin
          valid_d      = 1'b0;
          sink_ready_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_bad = 1'b1;
    endcase

    // Clear wins over any stage write, including the Clamp write of i_acc.
    if (clear) begin
      i_acc_d  = '0;
      seen_d   = 1'b0;
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
      i_wr_d   = 1'b0;
`ifdef PID_DERIV_FILTER_EN
      d_f_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state_bad) begin
      state_q      <= StIdle;
      sp_q         <= '0;
      meas_q       <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      kd_q         <= '0;
      err_prev_q   <= '0;
      seen_q       <= 1'b0;
      p_q          <= '0;
      i_inc_q      <= '0;
      d_q          <= '0;
      i_cand_q     <= '0;
      sum_q        <= '0;
      i_wr_q       <= 1'b0;
      i_acc_q      <= '0;
      sat_hi_q     <= 1'b0;
      sat_lo_q     <= 1'b0;
      pid_q        <= '0;
      sat_q        <= 1'b0;
      valid_q      <= 1'b0;
      sink_ready_q <= 1'b1;
`ifdef PID_DERIV_FILTER_EN
      d_f_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      meas_q       <= meas_d;
      kp_q         <= kp_d;
      ki_q         <= ki_d;
      kd_q         <= kd_d;
      err_prev_q   <= err_prev_d;
      seen_q       <= seen_d;
      p_q          <= p_d;
      i_inc_q      <= i_inc_d;
      d_q          <= d_d;
      i_cand_q     <= i_cand_d;
      sum_q        <= sum_d;
      i_wr_q       <= i_wr_d;
      i_acc_q      <= i_acc_d;
      sat_hi_q     <= sat_hi_d;
      sat_lo_q     <= sat_lo_d;
      pid_q        <= pid_d;
      sat_q        <= sat_d;
      valid_q      <= valid_d;
      sink_ready_q <= sink_ready_d;
`ifdef PID_DERIV_FILTER_EN
      d_f_q        <= d_f_d;
`endif
    end
  end

  assign sink_ready   = sink_ready_q;
  assign source_valid = valid_q;
  assign source_pid   = pid_q;
  assign source_sat   = sat_q;

endmodule

// File: tb/tb_pid_ctrl.sv
// tb_pid_ctrl: scoreboard bench for pid_ctrl with directed, hand-computed vectors.
// The driver pushes the expected result on each accept; a negedge monitor pops on every
// output handshake and compares command, saturation flag and (where marked) latency.
module tb_pid_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sink_valid;
  logic        sink_ready;
  logic [15:0] sink_setpoint;
  logic [15:0] sink_data;
  logic [7:0]  sink_kp, sink_ki, sink_kd;
  logic        clear;
  logic        source_valid;
  logic        source_ready;
  logic [14:0] source_pid;
  logic        source_sat;

  pid_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_setpoint(sink_setpoint),
    .sink_data    (sink_data),
    .sink_kp      (sink_kp),
    .sink_ki      (sink_ki),
    .sink_kd      (sink_kd),
    .clear        (clear),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_pid   (source_pid),
    .source_sat   (source_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pid;
    int sat;
    int acc_cyc;
    bit chk_lat;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0d, expected %0d", name, id, act, exp_v);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (source_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = source_valid;
    if (source_valid && source_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 0, int'(source_pid), -1);
      end else begin
        e = exp_q.pop_front();
        chk("pid", e.id, int'(source_pid), e.pid);
        chk("sat", e.id, int'(source_sat), e.sat);
        // Accept cycle N (sink_valid seen with sink_ready) -> valid first seen in cycle N+4.
        if (e.chk_lat) chk("latency", e.id, rise_cyc - e.acc_cyc, 4);
      end
    end
  end

  task automatic send(input int id, input int sp, input int meas, input int kp, input int ki,
                      input int kd, input int pid, input int sat, input bit lat, input bit push);
    bit acc = 1'b0;
    @(posedge clk);
    #1;
    sink_setpoint = 16'(sp);
    sink_data     = 16'(meas);
    sink_kp       = 8'(kp);
    sink_ki       = 8'(ki);
    sink_kd       = 8'(kd);
    sink_valid    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sink_ready) begin
        if (push) exp_q.push_back('{pid: pid, sat: sat, acc_cyc: cyc, chk_lat: lat, id: id});
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", id, 0, 1);
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
  endtask

  task automatic drain(input int id);
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !source_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk("drain_timeout", id, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  int d_second;
  int got_valid;

  initial begin
    reset = 1'b1; sink_valid = 1'b0; clear = 1'b0; source_ready = 1'b1;
    sink_setpoint = '0; sink_data = '0; sink_kp = '0; sink_ki = '0; sink_kd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 0, int'(source_valid), 0);
    chk("rst_ready", 0, int'(sink_ready), 1);
    chk("rst_pid", 0, int'(source_pid), 0);
    chk("rst_sat", 0, int'(source_sat), 0);

    // P only: 16*4080>>4 = 4080
    send(1, 4080, 0, 16, 0, 0, 4080, 0, 1'b1, 1'b1);
    drain(1);
    // High clamp: 255*4080>>4 = 65025 -> 12240
    send(2, 4080, 0, 255, 0, 0, 12240, 1, 1'b1, 1'b1);
    drain(2);
    // Previous output saturated high, positive increment is held: i stays 0
    send(3, 100, 0, 0, 16, 0, 0, 0, 1'b1, 1'b1);
    // History now unsaturated: integrates to 100
    send(4, 100, 0, 0, 16, 0, 100, 0, 1'b0, 1'b1);
    drain(4);

    // Low clamp: -500 -> 0
    do_clear();
    send(5, 0, 500, 16, 0, 0, 0, 1, 1'b1, 1'b1);
    drain(5);

    // Integrator ramp and clamp
    do_clear();
    send(6, 100, 0, 0, 16, 0, 100, 0, 1'b0, 1'b1);
    send(7, 100, 0, 0, 16, 0, 200, 0, 1'b0, 1'b1);
    send(8, 100, 0, 0, 16, 0, 300, 0, 1'b0, 1'b1);
    send(9, 4080, 0, 0, 255, 0, 12240, 0, 1'b0, 1'b1);
    send(10, 4080, 0, 0, 255, 0, 12240, 0, 1'b0, 1'b1);
    drain(10);
    do_clear();
    send(11, 100, 0, 0, 16, 0, 100, 0, 1'b0, 1'b1);
    drain(11);

    // Derivative: 0 then 16*200>>4 = 200 (filtered: 200>>>2 = 50), then negative -> clamp low
`ifdef PID_DERIV_FILTER_EN
    d_second = 50;
`else
    d_second = 200;
`endif
    do_clear();
    send(12, 100, 0, 0, 0, 16, 0, 0, 1'b0, 1'b1);
    send(13, 300, 0, 0, 0, 16, d_second, 0, 1'b0, 1'b1);
    send(14, 100, 0, 0, 0, 16, 0, 1, 1'b0, 1'b1);
    drain(14);

    // Back-pressure: result held 10 cycles, extra sample ignored
    do_clear();
    source_ready = 1'b0;
    send(15, 1000, 0, 16, 0, 0, 1000, 0, 1'b0, 1'b1);
    got_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (source_valid) begin
        got_valid = 1;
        break;
      end
    end
    chk("bp_valid_seen", 15, got_valid, 1);
    @(posedge clk);
    #1;
    sink_setpoint = 16'd2000; sink_data = '0; sink_kp = 8'd32; sink_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", 15, int'({source_valid, sink_ready, source_sat, source_pid}),
          int'({1'b1, 1'b0, 1'b0, 15'd1000}));
    end
    @(posedge clk);
    #1 sink_valid = 1'b0;
    @(posedge clk);
    #1 source_ready = 1'b1;
    drain(15);
    repeat (8) @(posedge clk);
    #1 chk("bp_ready_after", 15, int'(sink_ready), 1);

    // Reset while a sample sits in Sum
    do_clear();
    send(16, 100, 0, 0, 16, 0, 100, 0, 1'b0, 1'b1);
    drain(16);
    send(17, 100, 0, 0, 16, 0, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_sum_valid", 17, int'(source_valid), 0);
    chk("rst_sum_ready", 17, int'(sink_ready), 1);
    repeat (8) @(posedge clk);
    // i_acc restarted from 0: 100, not 200
    send(18, 100, 0, 0, 16, 0, 100, 0, 1'b1, 1'b1);
    drain(18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pid_ctrl.md
# pid_ctrl

Parametrised PID controller. It is the successor to the fixed 8-bit altitude PID and is shared by the altitude, attitude and yaw loops. It takes a signed setpoint/measurement pair through a valid/ready sink, computes P, I and D terms with saturating integrator anti-windup, and emits a clamped unsigned actuator command through a valid/ready source. It sits between the sensor-fusion blocks and the motor-mixer.

## Interface
- DATA_W, 16: width of signed setpoint and measurement.
- GAIN_W, 8: width of unsigned gains kp/ki/kd.
- FRAC_SHIFT, 4: arithmetic right shift applied to each gain×error product (gain = k/2^FRAC_SHIFT).
- OUT_W, 15: width of unsigned output.
- OUT_MAX, 12240: output upper clamp; must be < 2^OUT_W.
- I_MAX, 12240: integrator upper clamp; lower clamp is 0.
- DF_SHIFT, 2: derivative filter coefficient shift (used only with PID_DERIV_FILTER_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- sink_valid  in  1  input sample valid.
- sink_ready  out  1  block can accept a sample.
- sink_setpoint  in  DATA_W  signed setpoint.
- sink_data  in  DATA_W  signed measurement.
- sink_kp, sink_ki, sink_kd  in  GAIN_W  unsigned gains, sampled with the data.
- clear  in  1  zeroes integrator and derivative history.
- source_valid  out  1  result valid.
- source_ready  in  1  downstream accepts result.
- source_pid  out  OUT_W  clamped command.
- source_sat  out  1  result was clamped (high or low).

## Operation
- Internal arithmetic is signed, ACC_W = DATA_W+GAIN_W+4 bits. Gains are zero-extended. All intermediates are sign-extended to ACC_W.
- err = setpoint − data, computed at DATA_W+1 bits with no overflow.
- p = (kp·err)>>>FRAC_SHIFT.
- i_inc = (ki·err)>>>FRAC_SHIFT.
- d = (kd·(err − err_prev))>>>FRAC_SHIFT.
- First sample after reset or clear: err_prev is taken as err, so d = 0.
- Integrator:
  - i_cand = i_acc + i_inc, clamped to [0, I_MAX].
  - Conditional integration: if the previous output saturated high and i_inc > 0, or saturated low and i_inc < 0, i_acc is held.
- sum = p + i_cand + d. source_pid = sum clamped to [0, OUT_MAX]. source_sat = 1 when sum < 0 or sum > OUT_MAX.
- FSM states:
  - IDLE(0): sink_ready = 1. On sink_valid, latch setpoint, data and gains, then go to MUL.
  - MUL(1): register err, the three products and err_prev update. Go to SUM.
  - SUM(2): compute i_cand (with conditional integration) and sum. Go to CLAMP.
  - CLAMP(3): write i_acc, source_pid and source_sat; set source_valid = 1; record the saturation direction. Go to OUT.
  - OUT(4): hold all outputs stable. On source_ready, clear source_valid and go to IDLE.
  - Illegal encodings: go to IDLE with the reset values.
- clear: honoured in any state. It zeroes i_acc, the first-sample flag, the saturation history and the filter state. An in-flight sample completes using the values already latched. If clear coincides with the CLAMP edge, clear wins and i_acc = 0.
- reset: source_valid = 0, source_pid = 0, source_sat = 0, sink_ready = 1 after the edge, all internal registers 0, state IDLE. A pending output is discarded.

## Timing
- Accept edge = the edge where sink_valid && sink_ready.
- source_valid is high from the 3rd edge after accept (CLAMP edge) until the edge where source_ready is sampled high.
- If source_ready is already high, the pipeline has 4-cycle latency and a minimum sample period of 5 cycles.
- sink_ready is low in MUL/SUM/CLAMP/OUT. sink_valid is ignored while sink_ready is low.
- Back-pressure has no depth limit. source_pid and source_sat are stable while source_valid && !source_ready.

## Configuration
- PID_DERIV_FILTER_EN:
  - Defined: d is replaced by d_f, a first-order IIR, d_f ← d_f + ((d − d_f)>>>DF_SHIFT). d_f is updated in SUM, so latency is unchanged. d_f is zeroed on reset and clear.
  - Undefined: raw d is used and no filter register exists.

## Test plan
(Default parameters; filter disabled unless noted.)
- P only: setpoint 4080, data 0, kp 16, ki = kd = 0 -> source_pid 4080, sat 0, source_valid 4 edges after accept.
- High clamp: setpoint 4080, data 0, kp 255 -> sum 65025 -> source_pid 12240, sat 1.
- Low clamp: setpoint 0, data 500, kp 16 -> source_pid 0, sat 1.
- Integrator:
  - ki 16, err 100, three samples -> 100, 200, 300.
  - Then err 4080 with ki 255 -> i_acc clamps at 12240.
  - Then clear -> next err 100 sample gives 100.
- Derivative: kd 16, err 100 then 300 -> 0 then 200. With PID_DERIV_FILTER_EN: 0 then 50.
- Back-pressure/reset:
  - source_ready low 10 cycles -> outputs stable, sink_ready 0, extra sink_valid ignored.
  - reset asserted in SUM -> next cycle source_valid 0, sink_ready 1, i_acc 0.
